// File: rtl/decode_stage_pipe.sv
// Registered RV32I (optional M) decode stage between IF/ID and EX.
// Produces the control bundle, sign-extended immediate and register indices with valid/ready on both sides.
module decode_stage_pipe #(
  parameter int XLEN  = 32,
  parameter bit EN_M  = 1'b0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_imm,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic [24:0]      out_ctrl,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_count
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  logic             r_valid;
  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  r_imm;
  logic [4:0]       r_rs1, r_rs2, r_rd;
  logic [24:0]      r_ctrl;
  logic             r_illegal;
  logic [CNT_W-1:0] r_cnt;

  logic [6:0]      w_opcode;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic            w_accept;
  logic            w_illegal;
  logic            w_mul, w_branch, w_jump, w_pc_sel, w_reg_write;
  logic [2:0]      w_imm_src;
  logic [3:0]      w_wstrb_load, w_wstrb;
  logic            w_alu_src, w_u_s, w_mem_write;
  logic [3:0]      w_alu_ctrl, w_alu_func;
  logic [1:0]      w_res_src;
  logic [24:0]     w_ctrl;
  logic [XLEN-1:0] w_imm;

  assign w_opcode = in_instr[6:0];
  assign w_f3     = in_instr[14:12];
  assign w_f7     = in_instr[31:25];
  assign in_ready = !r_valid || out_ready;
  assign w_accept = in_valid && in_ready && !flush;

  // Shared OP / OP-IMM function decode; only register-register OP can subtract.
  always_comb begin
    w_alu_func = 4'b0000;
    case (w_f3)
      3'b000:  w_alu_func = (w_opcode == OPC_OP && in_instr[30]) ? 4'b0001 : 4'b0000;
      3'b001:  w_alu_func = 4'b0010;
      3'b010,
      3'b011:  w_alu_func = 4'b0011;
      3'b100:  w_alu_func = 4'b1010;
      3'b101:  w_alu_func = in_instr[30] ? 4'b0110 : 4'b0100;
      3'b110:  w_alu_func = 4'b1100;
      default: w_alu_func = 4'b1000;
    endcase
  end

  always_comb begin
    w_illegal    = 1'b0;
    w_mul        = 1'b0;
    w_branch     = 1'b0;
    w_jump       = 1'b0;
    w_pc_sel     = 1'b0;
    w_reg_write  = 1'b0;
    w_imm_src    = 3'b000;
    w_wstrb_load = 4'b1111;
    w_wstrb      = 4'b1111;
    w_alu_src    = 1'b0;
    w_u_s        = 1'b0;
    w_alu_ctrl   = 4'b0000;
    w_mem_write  = 1'b0;
    w_res_src    = 2'b00;
    case (w_opcode)
      OPC_LOAD: begin
        w_reg_write = 1'b1;
        w_alu_src   = 1'b1;
        w_res_src   = 2'b01;
        case (w_f3)
          3'b000:  w_wstrb_load = 4'b0001;
          3'b001:  w_wstrb_load = 4'b0011;
          3'b010:  w_wstrb_load = 4'b1111;
          3'b100:  begin w_wstrb_load = 4'b1001; w_u_s = 1'b1; end
          3'b101:  begin w_wstrb_load = 4'b1011; w_u_s = 1'b1; end
          default: w_illegal = 1'b1;
        endcase
      end
      OPC_STORE: begin
        w_mem_write = 1'b1;
        w_alu_src   = 1'b1;
        w_imm_src   = 3'b001;
        case (w_f3)
          3'b000:  w_wstrb = 4'b0001;
          3'b001:  w_wstrb = 4'b0011;
          3'b010:  w_wstrb = 4'b1111;
          default: w_illegal = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        w_reg_write = 1'b1;
        w_alu_src   = 1'b1;
        w_alu_ctrl  = w_alu_func;
        w_u_s       = (w_f3 == 3'b011);
      end
      OPC_OP: begin
        if (w_f7 == 7'b0000001) begin
          if (EN_M) begin
            w_mul       = 1'b1;
            w_reg_write = 1'b1;
            w_alu_ctrl  = 4'b1111;
          end else begin
            w_illegal = 1'b1;
          end
        end else begin
          w_reg_write = 1'b1;
          w_alu_ctrl  = w_alu_func;
          w_u_s       = (w_f3 == 3'b011);
        end
      end
      OPC_BRANCH: begin
        w_branch  = 1'b1;
        w_imm_src = 3'b010;
        w_u_s     = w_f3[1];
        case (w_f3)
          3'b000:  w_alu_ctrl = 4'b0101;
          3'b001:  w_alu_ctrl = 4'b0111;
          3'b100,
          3'b110:  w_alu_ctrl = 4'b1001;
          3'b101,
          3'b111:  w_alu_ctrl = 4'b1011;
          default: w_illegal = 1'b1;
        endcase
      end
      OPC_JALR: begin
        w_jump      = 1'b1;
        w_pc_sel    = 1'b1;
        w_reg_write = 1'b1;
        w_alu_src   = 1'b1;
        w_res_src   = 2'b10;
      end
      OPC_JAL: begin
        w_jump      = 1'b1;
        w_reg_write = 1'b1;
        w_imm_src   = 3'b011;
        w_res_src   = 2'b10;
      end
      OPC_AUIPC: begin
        w_reg_write = 1'b1;
        w_imm_src   = 3'b100;
        w_res_src   = 2'b11;
      end
      OPC_LUI: begin
        w_reg_write = 1'b1;
        w_imm_src   = 3'b101;
        w_alu_src   = 1'b1;
        w_alu_ctrl  = 4'b1110;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // An illegal instruction must not write anything downstream, so its whole bundle is zeroed.
  assign w_ctrl = w_illegal ? 25'd0 :
                  {w_mul, w_branch, w_jump, w_pc_sel, w_reg_write, w_imm_src, w_wstrb_load,
                   w_wstrb, w_alu_src, w_u_s, w_alu_ctrl, w_mem_write, w_res_src};

  always_comb begin
    case (w_imm_src)
      3'b001:  w_imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
      3'b010:  w_imm = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}));
      3'b011:  w_imm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}));
      3'b100,
      3'b101:  w_imm = XLEN'($signed({in_instr[31:12], 12'b0}));
      default: w_imm = XLEN'($signed(in_instr[31:20]));
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid   <= 1'b0;
      r_pc      <= '0;
      r_imm     <= '0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_rd      <= '0;
      r_ctrl    <= '0;
      r_illegal <= 1'b0;
      r_cnt     <= '0;
    end else begin
      if (flush) begin
        r_valid <= 1'b0;
      end else if (w_accept) begin
        r_valid   <= 1'b1;
        r_pc      <= in_pc;
        r_imm     <= w_imm;
        r_rs1     <= in_instr[19:15];
        r_rs2     <= in_instr[24:20];
        r_rd      <= in_instr[11:7];
        r_ctrl    <= w_ctrl;
        r_illegal <= w_illegal;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
      if (w_accept && w_illegal && (r_cnt != {CNT_W{1'b1}}))
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign out_valid     = r_valid;
  assign out_pc        = r_pc;
  assign out_imm       = r_imm;
  assign out_rs1       = r_rs1;
  assign out_rs2       = r_rs2;
  assign out_rd        = r_rd;
  assign out_ctrl      = r_ctrl;
  assign out_illegal   = r_illegal;
  assign illegal_count = r_cnt;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed bench for decode_stage_pipe: handshake, decode fields, flush, reset and counter saturation.
module tb_decode_stage_pipe;
  localparam int XLEN  = 32;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset, flush, in_valid, out_ready;
  logic             in_ready, out_valid, out_illegal;
  logic [31:0]      in_instr;
  logic [XLEN-1:0]  in_pc, out_pc, out_imm;
  logic [4:0]       out_rs1, out_rs2, out_rd;
  logic [24:0]      out_ctrl;
  logic [CNT_W-1:0] illegal_count;

  int checks = 0;
  int errors = 0;
  logic [24:0] held_ctrl;
  logic [31:0] held_imm;

  decode_stage_pipe #(.XLEN(XLEN), .EN_M(1'b0), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_imm(out_imm), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_ctrl(out_ctrl), .out_illegal(out_illegal), .illegal_count(illegal_count)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [24:0] mk(input logic mul, input logic br, input logic jp, input logic pcs,
                                     input logic rw, input logic [2:0] isrc, input logic [3:0] wl,
                                     input logic [3:0] ws, input logic as, input logic us,
                                     input logic [3:0] alu, input logic mw, input logic [1:0] rs);
    return {mul, br, jp, pcs, rw, isrc, wl, ws, as, us, alu, mw, rs};
  endfunction

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = 32'h0; in_pc = '0;
    cyc(); cyc();
    chk("rst_valid", out_valid, 0);
    chk("rst_ctrl", out_ctrl, 0);
    chk("rst_cnt", illegal_count, 0);
    chk("rst_imm", out_imm, 0);
    chk("rst_pc", out_pc, 0);
    reset = 1'b0;

    // addi x1,x0,-1
    in_valid = 1'b1; in_instr = 32'hFFF00093; in_pc = 32'h100; out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    $display("addi accepted");
    chk("addi_valid", out_valid, 1);
    chk("addi_imm", out_imm, 32'hFFFFFFFF);
    chk("addi_rd", out_rd, 1);
    chk("addi_pc", out_pc, 32'h100);
    chk("addi_ctrl", out_ctrl, mk(0,0,0,0,1,3'b000,4'b1111,4'b1111,1,0,4'b0000,0,2'b00));
    cyc();
    chk("drain_valid", out_valid, 0);
    out_ready = 1'b0;
    #1 chk("idle_ready", in_ready, 1);

    // sub x3,x1,x2 held by back-pressure; a waiting lhu must not slip in
    in_valid = 1'b1; in_instr = 32'h402081B3; in_pc = 32'h104;
    cyc();
    in_instr = 32'h00415283;
    held_ctrl = mk(0,0,0,0,1,3'b000,4'b1111,4'b1111,0,0,4'b0001,0,2'b00);
    $display("sub accepted, stalling");
    chk("sub_ctrl", out_ctrl, held_ctrl);
    chk("sub_rs1", out_rs1, 1);
    chk("sub_rs2", out_rs2, 2);
    chk("sub_rd", out_rd, 3);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_valid", out_valid, 1);
      chk("stall_ctrl", out_ctrl, held_ctrl);
      chk("stall_pc", out_pc, 32'h104);
      chk("stall_ready", in_ready, 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    #1 chk("release_ready", in_ready, 1);
    cyc();
    chk("sub_drained", out_valid, 0);

    // lhu x5,4(x2) then sb back to back
    in_valid = 1'b1; in_instr = 32'h00415283; in_pc = 32'h108;
    cyc();
    $display("lhu accepted");
    chk("lhu_ctrl", out_ctrl, mk(0,0,0,0,1,3'b000,4'b1011,4'b1111,1,1,4'b0000,0,2'b01));
    chk("lhu_imm", out_imm, 4);
    chk("lhu_rd", out_rd, 5);
    in_instr = 32'h00208023; in_pc = 32'h10C;
    cyc();
    $display("sb accepted");
    chk("sb_ctrl", out_ctrl, mk(0,0,0,0,0,3'b001,4'b1111,4'b0001,1,0,4'b0000,1,2'b00));
    chk("sb_pc", out_pc, 32'h10C);

    // lui x1,0x80000 : upper immediate sign-extends
    in_instr = 32'h800000B7;
    cyc();
    $display("lui accepted");
    chk("lui_ctrl", out_ctrl, mk(0,0,0,0,1,3'b101,4'b1111,4'b1111,1,0,4'b1110,0,2'b00));
    chk("lui_imm", out_imm, 32'h80000000);

    // bltu x1,x2,-8 : B-immediate and unsigned compare
    in_instr = 32'hFE20ECE3;
    cyc();
    $display("bltu accepted");
    chk("bltu_ctrl", out_ctrl, mk(0,1,0,0,0,3'b010,4'b1111,4'b1111,0,1,4'b1001,0,2'b00));
    chk("bltu_imm", out_imm, 32'hFFFFFFF8);

    // BRANCH func3=010 is illegal
    in_instr = 32'h00002063;
    cyc();
    $display("bad branch accepted");
    chk("badbr_ill", out_illegal, 1);
    chk("badbr_ctrl", out_ctrl, 0);
    chk("badbr_cnt", illegal_count, 1);

    // mul x0,x1,x2 is illegal without M support
    in_instr = 32'h02208033;
    cyc();
    $display("mul accepted");
    chk("mul_ill", out_illegal, 1);
    chk("mul_ctrl", out_ctrl, 0);
    chk("mul_cnt", illegal_count, 2);

    // flush while holding a valid instruction with an illegal beat arriving
    in_instr = 32'hFFF00093;
    cyc();
    chk("pre_flush_valid", out_valid, 1);
    chk("pre_flush_ill", out_illegal, 0);
    flush = 1'b1; out_ready = 1'b0; in_instr = 32'h0000007F;
    cyc();
    $display("flush applied");
    flush = 1'b0;
    chk("flush_valid", out_valid, 0);
    chk("flush_cnt", illegal_count, 2);

    // flood of illegal opcodes saturates the counter
    out_ready = 1'b1;
    cyc();
    chk("flood_first_cnt", illegal_count, 3);
    for (int i = 1; i < (1 << CNT_W) + 2; i++) cyc();
    $display("illegal flood done");
    chk("sat_cnt", illegal_count, {CNT_W{1'b1}});
    chk("sat_ill", out_illegal, 1);
    chk("sat_rw", out_ctrl[20], 0);
    chk("sat_valid", out_valid, 1);

    // reset mid-stream
    reset = 1'b1;
    cyc();
    reset = 1'b0; in_valid = 1'b0;
    $display("mid-stream reset");
    chk("mrst_valid", out_valid, 0);
    chk("mrst_ctrl", out_ctrl, 0);
    chk("mrst_cnt", illegal_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
